// File: rtl/blwl_prog_ctrl.sv
// BL/WL configuration-array programming sequencer: one row word per handshake, one word-line pulse per row.
// Optional read-back verify stage is enabled by defining BLWL_PROG_VERIFY_EN.
module blwl_prog_ctrl #(
  parameter int unsigned NUM_BL          = 8,
  parameter int unsigned NUM_WL          = 4,
  parameter int unsigned WL_PULSE_CYCLES = 2,
  localparam int unsigned RW  = (NUM_WL > 1) ? $clog2(NUM_WL) : 1,
  localparam int unsigned PCW = ($clog2(WL_PULSE_CYCLES + 1) > 1) ? $clog2(WL_PULSE_CYCLES + 1) : 1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [NUM_BL-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              done
`ifdef BLWL_PROG_VERIFY_EN
  ,
  input  logic [NUM_BL-1:0] rdata,
  output logic              err,
  output logic [RW-1:0]     err_row
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETUP  = 3'd2,
    S_PULSE  = 3'd3,
    S_HOLD   = 3'd4,
    S_VERIFY = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic [NUM_BL-1:0] bl_q, bl_d;
  logic              done_q, done_d;
`ifdef BLWL_PROG_VERIFY_EN
  logic [NUM_BL-1:0] word_q, word_d;
  logic              err_q, err_d;
  logic [RW-1:0]     err_row_q, err_row_d;
`endif

  // State and datapath registers
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      pcnt_q  <= '0;
      bl_q    <= '0;
      done_q  <= 1'b0;
`ifdef BLWL_PROG_VERIFY_EN
      word_q    <= '0;
      err_q     <= 1'b0;
      err_row_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pcnt_q  <= pcnt_d;
      bl_q    <= bl_d;
      done_q  <= done_d;
`ifdef BLWL_PROG_VERIFY_EN
      word_q    <= word_d;
      err_q     <= err_d;
      err_row_q <= err_row_d;
`endif
    end
  end

  // Next-state logic; a row ends in HOLD (or VERIFY) with the same exit rules
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    pcnt_d  = pcnt_q;
    bl_d    = bl_q;
    done_d  = done_q;
`ifdef BLWL_PROG_VERIFY_EN
    word_d    = word_q;
    err_d     = err_q;
    err_row_d = err_row_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          done_d  = 1'b0;
          state_d = S_LOAD;
`ifdef BLWL_PROG_VERIFY_EN
          err_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (din_valid) begin
          bl_d    = din;
          state_d = S_SETUP;
`ifdef BLWL_PROG_VERIFY_EN
          word_d = din;
`endif
        end
      end
      S_SETUP: begin
        pcnt_d  = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        pcnt_d = pcnt_q + PCW'(1);
        if (pcnt_q == PCW'(WL_PULSE_CYCLES - 1)) state_d = S_HOLD;
      end
`ifdef BLWL_PROG_VERIFY_EN
      S_HOLD: begin
        bl_d    = '0;
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        if (rdata != word_q) begin
          err_d = 1'b1;
          if (!err_q) err_row_d = row_q;
        end
        if (row_q == RW'(NUM_WL - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_LOAD;
        end
      end
`else
      S_HOLD: begin
        if (row_q == RW'(NUM_WL - 1)) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          row_d   = row_q + RW'(1);
          state_d = S_LOAD;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state
  assign busy      = (state_q != S_IDLE);
  assign din_ready = (state_q == S_LOAD);
  assign bl        = bl_q;
  assign done      = done_q;
`ifdef BLWL_PROG_VERIFY_EN
  assign wl      = ((state_q == S_PULSE) || (state_q == S_VERIFY)) ? (NUM_WL'(1) << row_q) : '0;
  assign err     = err_q;
  assign err_row = err_row_q;
`else
  assign wl = (state_q == S_PULSE) ? (NUM_WL'(1) << row_q) : '0;
`endif

endmodule

// File: tb/tb_blwl_prog_ctrl.sv
// Self-checking bench for blwl_prog_ctrl: per-cycle expected trace built from row timing rules.
module tb_blwl_prog_ctrl;
  localparam int unsigned NBL = 4;
  localparam int unsigned NWL = 3;
  localparam int unsigned P   = 2;
`ifdef BLWL_PROG_VERIFY_EN
  localparam int unsigned ROW_CYC = 4 + P;
`else
  localparam int unsigned ROW_CYC = 3 + P;
`endif
  localparam int unsigned WL_HIGH = ROW_CYC - 3;

  logic           prog_clk = 1'b0;
  logic           pReset, start, din_valid;
  logic [NBL-1:0] din;
  logic           din_ready, busy, done;
  logic [NBL-1:0] bl;
  logic [NWL-1:0] wl;
`ifdef BLWL_PROG_VERIFY_EN
  logic [NBL-1:0] rdata;
  logic           err;
  logic [1:0]     err_row;
  logic [NBL-1:0] vwords [NWL];
  bit             bad2 = 1'b0;
  always_comb begin
    rdata = '0;
    for (int r = 0; r < int'(NWL); r++)
      if (wl[r]) rdata = (bad2 && r == 2) ? '0 : vwords[r];
  end
`endif

  int checks = 0, failures = 0;

  blwl_prog_ctrl #(.NUM_BL(NBL), .NUM_WL(NWL), .WL_PULSE_CYCLES(P)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .bl(bl), .wl(wl),
    .busy(busy), .done(done)
`ifdef BLWL_PROG_VERIFY_EN
    , .rdata(rdata), .err(err), .err_row(err_row)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Stimulus/expectation per cycle, and observed outputs
  logic           q_valid[$], q_start[$];
  logic [NBL-1:0] q_din[$];
  logic [NWL-1:0] e_wl[$], o_wl[$];
  logic [NBL-1:0] e_bl[$], o_bl[$];
  logic           e_busy[$], e_rdy[$], e_done[$], o_busy[$], o_rdy[$], o_done[$];
  logic [NBL-1:0] model_bl = '0;

  // Continuous properties: one-hot word lines, bit lines frozen while a word line was high
  logic [NWL-1:0] p_wl = '0;
  logic [NBL-1:0] p_bl = '0;
  logic           edge_rst = 1'b1;
  bit             prop_en = 1'b0;
  always @(posedge prog_clk) edge_rst <= pReset;
  always @(negedge prog_clk) begin
    if (prop_en) begin
      checks++;
      if (!$onehot0(wl)) begin
        failures++;
        $display("FAIL onehot0_wl t=%0t wl=%b", $time, wl);
      end
      checks++;
      if (p_wl != '0 && !edge_rst && bl !== p_bl) begin
        failures++;
        $display("FAIL bl_stable_under_wl t=%0t bl=%h required=%h prev_wl=%b", $time, bl, p_bl, p_wl);
      end
    end
    p_wl = wl;
    p_bl = bl;
  end

  task automatic push_cyc(input logic v, input logic [NBL-1:0] d, input logic s,
                          input logic [NWL-1:0] ewl, input logic [NBL-1:0] ebl,
                          input logic eb, input logic er, input logic ed);
    q_valid.push_back(v); q_din.push_back(d); q_start.push_back(s);
    e_wl.push_back(ewl); e_bl.push_back(ebl);
    e_busy.push_back(eb); e_rdy.push_back(er); e_done.push_back(ed);
  endtask

  // Reference: each row = stall LOADs, accepting LOAD, SETUP, P pulse cycles, HOLD (+VERIFY), then done
  task automatic build_pass(input logic [NBL-1:0] w [NWL], input int stall [NWL], input bit noise);
    logic [NBL-1:0] prev;
    logic [NWL-1:0] sel;
    q_valid.delete(); q_din.delete(); q_start.delete();
    e_wl.delete(); e_bl.delete(); e_busy.delete(); e_rdy.delete(); e_done.delete();
    prev = model_bl;
    for (int r = 0; r < int'(NWL); r++) begin
      sel = NWL'(1) << r;
`ifdef BLWL_PROG_VERIFY_EN
      vwords[r] = w[r];
`endif
      for (int s = 0; s < stall[r]; s++)
        push_cyc(1'b0, NBL'($urandom), noise & $urandom_range(0, 1), '0, prev, 1'b1, 1'b1, 1'b0);
      push_cyc(1'b1, w[r], noise & $urandom_range(0, 1), '0, prev, 1'b1, 1'b1, 1'b0);
      push_cyc(noise & $urandom_range(0, 1), NBL'($urandom), noise & $urandom_range(0, 1), '0, w[r], 1'b1, 1'b0, 1'b0);
      for (int p = 0; p < int'(P); p++)
        push_cyc(noise & $urandom_range(0, 1), NBL'($urandom), noise & $urandom_range(0, 1), sel, w[r], 1'b1, 1'b0, 1'b0);
      push_cyc(noise & $urandom_range(0, 1), NBL'($urandom), noise & $urandom_range(0, 1), '0, w[r], 1'b1, 1'b0, 1'b0);
`ifdef BLWL_PROG_VERIFY_EN
      push_cyc(noise & $urandom_range(0, 1), NBL'($urandom), noise & $urandom_range(0, 1), sel, '0, 1'b1, 1'b0, 1'b0);
      prev = '0;
`else
      prev = w[r];
`endif
    end
    push_cyc(1'b0, '0, 1'b0, '0, prev, 1'b0, 1'b0, 1'b1);
    model_bl = prev;
  endtask

  // Drives one pass from the built schedule and records outputs each cycle
  task automatic run_pass();
    o_wl.delete(); o_bl.delete(); o_busy.delete(); o_rdy.delete(); o_done.delete();
    @(negedge prog_clk);
    start = 1'b1; din_valid = 1'b0;
    for (int k = 0; k < q_valid.size(); k++) begin
      @(negedge prog_clk);
      o_wl.push_back(wl); o_bl.push_back(bl);
      o_busy.push_back(busy); o_rdy.push_back(din_ready); o_done.push_back(done);
      start = q_start[k]; din_valid = q_valid[k]; din = q_din[k];
    end
    start = 1'b0; din_valid = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0;
    repeat (2) @(negedge prog_clk);
    checks++;
    if ({wl, bl, busy, din_ready, done} !== '0) begin
      failures++;
      $display("FAIL reset_values wl=%b bl=%h busy=%b rdy=%b done=%b required all 0", wl, bl, busy, din_ready, done);
    end
    pReset = 1'b0;
    model_bl = '0;
    prop_en = 1'b1;
  endtask

  task automatic test_full_pass();
    logic [NBL-1:0] w [NWL];
    int st [NWL];
    int cnt;
    w[0] = 4'hA; w[1] = 4'h5; w[2] = 4'hF;
    st[0] = 0; st[1] = 0; st[2] = 0;
    build_pass(w, st, 1'b0);
    run_pass();
    for (int k = 0; k < e_wl.size(); k++) begin
      checks++;
      if ({o_wl[k], o_bl[k], o_busy[k], o_rdy[k], o_done[k]} !== {e_wl[k], e_bl[k], e_busy[k], e_rdy[k], e_done[k]}) begin
        failures++;
        $display("FAIL full_pass cyc=%0d got wl=%b bl=%h busy=%b rdy=%b done=%b required wl=%b bl=%h busy=%b rdy=%b done=%b",
                 k, o_wl[k], o_bl[k], o_busy[k], o_rdy[k], o_done[k], e_wl[k], e_bl[k], e_busy[k], e_rdy[k], e_done[k]);
      end
    end
    for (int r = 0; r < int'(NWL); r++) begin
      cnt = 0;
      for (int k = 0; k < o_wl.size(); k++) if (o_wl[k] == (NWL'(1) << r)) cnt++;
      checks++;
      if (cnt != int'(WL_HIGH)) begin
        failures++;
        $display("FAIL wl_pulse_len row=%0d got=%0d required=%0d", r, cnt, WL_HIGH);
      end
    end
    checks++;
    if (o_done[NWL*ROW_CYC] !== 1'b1 || o_done[NWL*ROW_CYC-1] !== 1'b0 || o_busy[NWL*ROW_CYC] !== 1'b0) begin
      failures++;
      $display("FAIL done_timing got done@%0d=%b done@%0d=%b busy=%b required 1,0,0", NWL*ROW_CYC,
               o_done[NWL*ROW_CYC], NWL*ROW_CYC-1, o_done[NWL*ROW_CYC-1], o_busy[NWL*ROW_CYC]);
    end
  endtask

  task automatic test_stall();
    logic [NBL-1:0] w [NWL];
    int st [NWL];
    for (int r = 0; r < int'(NWL); r++) begin w[r] = NBL'($urandom); st[r] = 0; end
    st[1] = 5;
    build_pass(w, st, 1'b0);
    run_pass();
    for (int k = 0; k < e_wl.size(); k++) begin
      checks++;
      if ({o_wl[k], o_bl[k], o_busy[k], o_rdy[k], o_done[k]} !== {e_wl[k], e_bl[k], e_busy[k], e_rdy[k], e_done[k]}) begin
        failures++;
        $display("FAIL stall cyc=%0d got wl=%b bl=%h rdy=%b done=%b required wl=%b bl=%h rdy=%b done=%b",
                 k, o_wl[k], o_bl[k], o_rdy[k], o_done[k], e_wl[k], e_bl[k], e_rdy[k], e_done[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [NBL-1:0] w [NWL];
    int st [NWL];
    for (int r = 0; r < int'(NWL); r++) begin w[r] = NBL'($urandom); st[r] = 0; end
    build_pass(w, st, 1'b0);
    q_start[ROW_CYC + 2] = 1'b1;
    run_pass();
    for (int k = 0; k < e_wl.size(); k++) begin
      checks++;
      if ({o_wl[k], o_bl[k], o_busy[k], o_done[k]} !== {e_wl[k], e_bl[k], e_busy[k], e_done[k]}) begin
        failures++;
        $display("FAIL start_ignored cyc=%0d got wl=%b bl=%h busy=%b done=%b required wl=%b bl=%h busy=%b done=%b",
                 k, o_wl[k], o_bl[k], o_busy[k], o_done[k], e_wl[k], e_bl[k], e_busy[k], e_done[k]);
      end
    end
    repeat (3) @(negedge prog_clk);
    checks++;
    if (busy !== 1'b0 || wl !== '0 || done !== 1'b1) begin
      failures++;
      $display("FAIL no_extra_rows got busy=%b wl=%b done=%b required 0,0,1", busy, wl, done);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [NBL-1:0] w [NWL];
    int st [NWL];
    for (int r = 0; r < int'(NWL); r++) begin w[r] = NBL'($urandom) | NBL'(1); st[r] = 0; end
    build_pass(w, st, 1'b0);
    @(negedge prog_clk);
    start = 1'b1;
    for (int k = 0; k <= int'(ROW_CYC) + 2; k++) begin
      @(negedge prog_clk);
      start = q_start[k]; din_valid = q_valid[k]; din = q_din[k];
    end
    checks++;
    if (wl !== 3'b010) begin
      failures++;
      $display("FAIL reset_mid_precond got wl=%b required 010", wl);
    end
    pReset = 1'b1;
    @(negedge prog_clk);
    checks++;
    if ({wl, bl, busy, din_ready, done} !== '0) begin
      failures++;
      $display("FAIL reset_mid got wl=%b bl=%h busy=%b rdy=%b done=%b required all 0", wl, bl, busy, din_ready, done);
    end
    pReset = 1'b0; din_valid = 1'b1; din = NBL'($urandom);
    model_bl = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge prog_clk);
      checks++;
      if (wl !== '0 || busy !== 1'b0 || bl !== '0) begin
        failures++;
        $display("FAIL reset_mid_quiet cyc=%0d got wl=%b busy=%b bl=%h required 0,0,0", k, wl, busy, bl);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_random_passes();
    logic [NBL-1:0] w [NWL];
    int st [NWL];
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < int'(NWL); r++) begin w[r] = NBL'($urandom); st[r] = $urandom_range(0, 3); end
      build_pass(w, st, 1'b1);
      run_pass();
      for (int k = 0; k < e_wl.size(); k++) begin
        checks++;
        if ({o_wl[k], o_bl[k], o_busy[k], o_rdy[k], o_done[k]} !== {e_wl[k], e_bl[k], e_busy[k], e_rdy[k], e_done[k]}) begin
          failures++;
          $display("FAIL random pass=%0d cyc=%0d got wl=%b bl=%h busy=%b rdy=%b done=%b required wl=%b bl=%h busy=%b rdy=%b done=%b",
                   n, k, o_wl[k], o_bl[k], o_busy[k], o_rdy[k], o_done[k], e_wl[k], e_bl[k], e_busy[k], e_rdy[k], e_done[k]);
        end
      end
    end
  endtask

`ifdef BLWL_PROG_VERIFY_EN
  task automatic test_verify();
    logic [NBL-1:0] w [NWL];
    int st [NWL];
    w[0] = 4'hA; w[1] = 4'h5; w[2] = 4'hF;
    st[0] = 0; st[1] = 0; st[2] = 0;
    bad2 = 1'b1;
    build_pass(w, st, 1'b0);
    run_pass();
    checks++;
    if (err !== 1'b1 || err_row !== 2'd2) begin
      failures++;
      $display("FAIL verify_err got err=%b err_row=%0d required 1,2", err, err_row);
    end
    bad2 = 1'b0;
    build_pass(w, st, 1'b0);
    run_pass();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL verify_clear got err=%b required 0", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_pass();
    test_stall();
    test_start_ignored();
    test_reset_mid_pulse();
    test_random_passes();
`ifdef BLWL_PROG_VERIFY_EN
    test_verify();
`endif
    @(negedge prog_clk);
    prop_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/blwl_prog_ctrl.md
# blwl_prog_ctrl

Programming sequencer for a BL/WL-addressed configuration memory array of NUM_WL rows × NUM_BL columns of single-bit SRAM cells. It accepts one row word per valid/ready transfer and drives the shared bit lines with that word. It then pulses exactly one word line so the addressed row latches the word, and advances row by row until the array is written. It sits between the bitstream loader and the array's `bl`/`wl` nets.

## Interface
Parameters:
- `NUM_BL`, 8: number of bit lines, which is also the row word width (≥1).
- `NUM_WL`, 4: number of word lines, which is also the row count (≥1).
- `WL_PULSE_CYCLES`, 2: number of cycles each word line is held high (≥1).

Ports:
- `prog_clk` input 1: the single clock.
- `pReset` input 1: reset, synchronous and active-high.
- `start` input 1: begin a programming pass. Sampled only in IDLE.
- `din` input NUM_BL: row word. `din[i]` is driven onto `bl[i]`.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: controller accepts `din` this cycle.
- `bl` output NUM_BL: bit-line drive.
- `wl` output NUM_WL: word-line drive, one-hot or zero.
- `busy` output 1: a pass is in progress.
- `done` output 1: the last pass completed.

## Operation
- FSM states: IDLE, LOAD, SETUP, PULSE, HOLD. The VERIFY state is added only with the macro (see Configuration).
- Row counter `row` has width max(1,$clog2(NUM_WL)). Pulse counter `pcnt` has width max(1,$clog2(WL_PULSE_CYCLES+1)).
- IDLE:
  - `busy`=0, `din_ready`=0, `wl`=0.
  - `bl` holds its last value.
  - On `start`=1: `row`←0, `done`←0, go to LOAD.
- LOAD:
  - `busy`=1, `din_ready`=1, `wl`=0.
  - On `din_valid`: `bl`←`din`, go to SETUP.
  - Waits indefinitely otherwise.
- SETUP: one cycle with `bl` stable and `wl`=0. Then `pcnt`←0 and go to PULSE.
- PULSE:
  - `wl`=one-hot(`row`), `bl` stable.
  - Increment `pcnt`. When `pcnt`==WL_PULSE_CYCLES-1, go to HOLD.
- HOLD: one cycle with `wl`=0 and `bl` still stable.
  - If `row`==NUM_WL-1: go to IDLE and set `done`←1.
  - Else: `row`←`row`+1 and go to LOAD.
- `din_ready` is 1 only in LOAD. `din` presented in any other state is neither consumed nor dropped; the producer holds it.
- `start` while `busy`=1 is ignored.
- `done` stays high until the next accepted `start` or `pReset`.
- No word line may ever be high while `bl` changes. `bl` changes only on the LOAD→SETUP edge.
- `pReset`=1 in any state takes effect at the next edge:
  - state←IDLE, `wl`←0, `bl`←0, `row`←0, `pcnt`←0.
  - `busy`=0, `done`=0, `din_ready`=0.
  - A partially written row is abandoned, and no further WL pulse occurs.

## Timing
- Reset values of all outputs: 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- `start` accepted at edge t: `busy` and `din_ready` are high from t+1.
- `din` accepted at edge t:
  - SETUP in t+1.
  - `wl` high for WL_PULSE_CYCLES cycles from t+2.
  - HOLD follows the pulse.
- Per row with `din_valid` held high: 3+WL_PULSE_CYCLES cycles (LOAD 1, SETUP 1, PULSE P, HOLD 1).
- A full pass takes NUM_WL·(3+P) cycles from the first LOAD.
- `done` rises the cycle after the final HOLD. `busy` falls in the same cycle.
- Boundary case NUM_WL=1: the single row goes HOLD→IDLE directly.
- Boundary case WL_PULSE_CYCLES=1: PULSE lasts exactly one cycle.

## Configuration
- Macro: `BLWL_PROG_VERIFY_EN`.
- Defined:
  - Adds port `rdata` input NUM_BL, the array read-back of the currently selected row.
  - Adds ports `err` output 1 and `err_row` output max(1,$clog2(NUM_WL)).
  - HOLD goes to VERIFY. VERIFY lasts one cycle, with `wl`=one-hot(`row`) and `bl` released to 0.
  - In VERIFY, `rdata` is compared with the captured word. On mismatch, `err`←1; if `err` was 0, `err_row`←`row`.
  - `err` is sticky until `start` or `pReset`, and both outputs reset to 0.
  - VERIFY then applies the HOLD exit rules. Per-row time becomes 4+P cycles.
- Undefined: none of these ports or the VERIFY state exist, and behaviour is exactly as above.

## Test plan
All scenarios use NUM_BL=4, NUM_WL=3, P=2.
- Full pass with words 4'hA, 4'h5, 4'hF and `din_valid` always high:
  - `wl` sequence 3'b001, 3'b010, 3'b100, each pulse 2 cycles.
  - `bl` is 4'hA/4'h5/4'hF during the respective pulses.
  - `done`=1 exactly 15 cycles after the first LOAD.
- Producer stalls 5 cycles before row 1: `din_ready` stays high, `wl`=0 throughout the stall, then the pass resumes correctly.
- `start` pulsed during row 1 PULSE: ignored, and the pass completes with no extra rows.
- `pReset` asserted in the first PULSE cycle of row 1: on the next edge, `wl`=0, `bl`=0, `busy`=0, `done`=0, and no further WL activity.
- Property check over all runs: `bl` never changes while `wl`≠0, and `$onehot0(wl)` holds always.
- With `BLWL_PROG_VERIFY_EN`, `rdata` forced to 4'h0 on row 2 only:
  - `err`=1 and `err_row`=2 after the pass.
  - A new `start` clears `err`.
